dec_exc_update: RTL and testbench

//  Decoder-side excitation rebuild for one subframe of the G.729 decoder:
//  exc[i] = round(L_shl(L_mac(L_mult(exc[i],gain_pit), code[i], gain_code), 1)) for i = 0..L_SUBFR-1.

---
 rtl/dec_exc_update.sv | 179 +++++++++++++++++
 tb/tb_dec_exc_update.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_exc_update.sv
// Decoder excitation rebuild for one subframe:
// exc[i] = round(L_shl(L_mac(L_mult(exc[i],gp), code[i], gc), 1)).
module dec_exc_update #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] exc,
    input  logic [ADDR_W-1:0] code,
    input  logic [15:0]       gain_pit,
    input  logic [15:0]       gain_code,
    input  logic [15:0]       L_SUBFR,
    input  logic [15:0]       addIn,
    input  logic [31:0]       L_multIn,
    input  logic [31:0]       L_macIn,
    input  logic [31:0]       L_shlIn,
    input  logic              L_shlDone,
    input  logic [31:0]       L_addIn,
    input  logic [31:0]       memIn,
    output logic [15:0]       addOutA,
    output logic [15:0]       addOutB,
    output logic [15:0]       L_multOutA,
    output logic [15:0]       L_multOutB,
    output logic [15:0]       L_macOutA,
    output logic [15:0]       L_macOutB,
    output logic [31:0]       L_macOutC,
    output logic              L_shlReady,
    output logic [31:0]       L_shlOutA,
    output logic [15:0]       L_shlOutB,
    output logic [31:0]       L_addOutA,
    output logic [31:0]       L_addOutB,
    output logic [ADDR_W-1:0] memReadAddr,
    output logic [ADDR_W-1:0] memWriteAddr,
    output logic [31:0]       memOut,
    output logic              memWriteEn,
    output logic              done
);

    typedef enum logic [3:0] {
        INIT,
        FOR_CHECK,
        L_MULT,
        L_MAC,
        L_SHL,
        ROUND,
        WRITE,
        INC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] i_q, i_d;
    logic [31:0] l_temp_q, l_temp_d;
    logic [15:0] gp_q, gp_d;
    logic [15:0] gc_q, gc_d;

    logic [15:0] exc_ext;
    logic [15:0] code_ext;
    logic        unused_ok;

    assign exc_ext   = {{(16 - ADDR_W){1'b0}}, exc};
    assign code_ext  = {{(16 - ADDR_W){1'b0}}, code};
    assign unused_ok = ^memIn[31:16];

    // Shared-unit ports are driven combinationally so results return in the same cycle.
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        l_temp_d     = l_temp_q;
        gp_d         = gp_q;
        gc_d         = gc_q;
        addOutA      = '0;
        addOutB      = '0;
        L_multOutA   = '0;
        L_multOutB   = '0;
        L_macOutA    = '0;
        L_macOutB    = '0;
        L_macOutC    = '0;
        L_shlReady   = 1'b0;
        L_shlOutA    = '0;
        L_shlOutB    = '0;
        L_addOutA    = '0;
        L_addOutB    = '0;
        memReadAddr  = '0;
        memWriteAddr = '0;
        memOut       = '0;
        memWriteEn   = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            INIT: begin
                i_d = '0;
                if (start) begin
                    gp_d    = gain_pit;
                    gc_d    = gain_code;
                    state_d = FOR_CHECK;
                end
            end
            FOR_CHECK: begin
                if (i_q < L_SUBFR) begin
                    addOutA     = exc_ext;
                    addOutB     = i_q;
                    memReadAddr = addIn[ADDR_W-1:0];
                    state_d     = L_MULT;
                end else begin
                    state_d = DONE;
                end
            end
            L_MULT: begin
                L_multOutA  = memIn[15:0];
                L_multOutB  = gp_q;
                l_temp_d    = L_multIn;
                addOutA     = code_ext;
                addOutB     = i_q;
                memReadAddr = addIn[ADDR_W-1:0];
                state_d     = L_MAC;
            end
            L_MAC: begin
                L_macOutA = memIn[15:0];
                L_macOutB = gc_q;
                L_macOutC = l_temp_q;
                l_temp_d  = L_macIn;
                state_d   = L_SHL;
            end
            L_SHL: begin
                L_shlReady = 1'b1;
                L_shlOutA  = l_temp_q;
                L_shlOutB  = 16'd1;
                if (L_shlDone) begin
                    l_temp_d = L_shlIn;
                    state_d  = ROUND;
                end
            end
            ROUND: begin
                L_addOutA = l_temp_q;
                L_addOutB = 32'h0000_8000;
                l_temp_d  = L_addIn;
                state_d   = WRITE;
            end
            WRITE: begin
                addOutA      = exc_ext;
                addOutB      = i_q;
                memWriteAddr = addIn[ADDR_W-1:0];
                memOut       = {{16{l_temp_q[31]}}, l_temp_q[31:16]};
                memWriteEn   = 1'b1;
                state_d      = INC;
            end
            INC: begin
                addOutA = i_q;
                addOutB = 16'd1;
                i_d     = addIn;
                state_d = FOR_CHECK;
            end
            DONE: begin
                done    = 1'b1;
                state_d = INIT;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= INIT;
            i_q      <= '0;
            l_temp_q <= '0;
            gp_q     <= '0;
            gc_q     <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            l_temp_q <= l_temp_d;
            gp_q     <= gp_d;
            gc_q     <= gc_d;
        end
    end

endmodule

// File: tb/tb_dec_exc_update.sv
// Randomised scoreboard bench for dec_exc_update with behavioural
// shared arithmetic units and a registered scratch memory.
module tb_dec_exc_update;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset, start;
    logic [AW-1:0] exc, code;
    logic [15:0]   gain_pit, gain_code, L_SUBFR, addIn;
    logic [31:0]   L_multIn, L_macIn, L_shlIn, L_addIn, memIn;
    logic          L_shlDone;
    logic [15:0]   addOutA, addOutB, L_multOutA, L_multOutB;
    logic [15:0]   L_macOutA, L_macOutB, L_shlOutB;
    logic [31:0]   L_macOutC, L_shlOutA, L_addOutA, L_addOutB, memOut;
    logic          L_shlReady, memWriteEn, done;
    logic [AW-1:0] memReadAddr, memWriteAddr;

    dec_exc_update #(.ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .exc(exc), .code(code),
        .gain_pit(gain_pit), .gain_code(gain_code),
        .L_SUBFR(L_SUBFR), .addIn(addIn),
        .L_multIn(L_multIn), .L_macIn(L_macIn),
        .L_shlIn(L_shlIn), .L_shlDone(L_shlDone),
        .L_addIn(L_addIn), .memIn(memIn),
        .addOutA(addOutA), .addOutB(addOutB),
        .L_multOutA(L_multOutA), .L_multOutB(L_multOutB),
        .L_macOutA(L_macOutA), .L_macOutB(L_macOutB),
        .L_macOutC(L_macOutC), .L_shlReady(L_shlReady),
        .L_shlOutA(L_shlOutA), .L_shlOutB(L_shlOutB),
        .L_addOutA(L_addOutA), .L_addOutB(L_addOutB),
        .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
        .memOut(memOut), .memWriteEn(memWriteEn), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_done;
        int          addr;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          shl_delay = 0;
    int          shl_cnt = 0;
    logic [31:0] mem[0:4095];
    logic [15:0] ev[0:63];
    logic [15:0] cv[0:63];
    logic [31:0] cw[0:63];
    logic [31:0] ew[0:63];
    bit          prev_wait = 0;

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx32(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: the Q-format formula with 32-bit saturation at each operator.
    function automatic logic [15:0] ref_exc(
        input logic [15:0] e, input logic [15:0] c,
        input logic [15:0] gp, input logic [15:0] gc);
        longint a, b, s;
        a = sat(2 * sx(e) * sx(gp));
        b = sat(2 * sx(c) * sx(gc));
        s = sat(a + b);
        s = sat(2 * s);
        s = sat(s + 32768);
        return s[31:16];
    endfunction

    // Behavioural shared units
    always_comb begin
        addIn     = addOutA + addOutB;
        L_multIn  = 32'(sat(2 * sx(L_multOutA) * sx(L_multOutB)));
        L_macIn   = 32'(sat(sx32(L_macOutC)
                    + sat(2 * sx(L_macOutA) * sx(L_macOutB))));
        L_shlIn   = 32'(sat(sx32(L_shlOutA) <<< L_shlOutB[4:0]));
        L_addIn   = 32'(sat(sx32(L_addOutA) + sx32(L_addOutB)));
        L_shlDone = L_shlReady && (shl_cnt == shl_delay);
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (L_shlReady && !L_shlDone) shl_cnt <= shl_cnt + 1;
        else shl_cnt <= 0;
    end

    always @(posedge clock) begin
        memIn <= mem[memReadAddr];
        if (memWriteEn) mem[memWriteAddr] = memOut;
    end

    // Monitor: pops the scoreboard whenever the DUT writes or finishes.
    always @(negedge clock) begin
        if (!reset) begin
            if (prev_wait) begin
                tests++;
                if (!L_shlReady) begin
                    fails++;
                    $display("FAIL shl_hold: L_shlReady=0 required 1");
                end
            end
            prev_wait = L_shlReady && !L_shlDone;
            if (memWriteEn) begin
                tests++;
                if (q.size() == 0 || q[0].is_done) begin
                    fails++;
                    $display("FAIL write_unexp: addr=%0d data=%h",
                             memWriteAddr, memOut);
                end else begin
                    if (int'(memWriteAddr) != q[0].addr ||
                        memOut !== q[0].data) begin
                        fails++;
                        $display("FAIL write: got %0d/%h required %0d/%h",
                                 memWriteAddr, memOut,
                                 q[0].addr, q[0].data);
                    end
                    void'(q.pop_front());
                end
            end
            if (done) begin
                tests++;
                if (q.size() == 0 || !q[0].is_done) begin
                    fails++;
                    $display("FAIL done_unexp: at lat %0d",
                             cyc - start_cyc + 1);
                end else begin
                    if (cyc - start_cyc + 1 != q[0].lat) begin
                        fails++;
                        $display("FAIL done_lat: got %0d required %0d",
                                 cyc - start_cyc + 1, q[0].lat);
                    end
                    void'(q.pop_front());
                end
            end
        end else begin
            prev_wait = 0;
        end
    end

    task automatic load(input int n, input int eb, input int cb);
        for (int i = 0; i < n; i++) begin
            ew[i] = {16'($urandom), ev[i]};
            cw[i] = {16'($urandom), cv[i]};
            mem[eb + i] = ew[i];
            mem[cb + i] = cw[i];
        end
    endtask

    task automatic kick(input int n, input logic [15:0] gp,
                        input logic [15:0] gc, input int eb,
                        input int cb);
        @(negedge clock);
        exc       = AW'(eb);
        code      = AW'(cb);
        L_SUBFR   = 16'(n);
        gain_pit  = gp;
        gain_code = gc;
        start     = 1'b1;
        @(negedge clock);
        start_cyc = cyc;
        start     = 1'b0;
        gain_pit  = 16'($urandom);
        gain_code = 16'($urandom);
    endtask

    task automatic wait_empty(input string name);
        for (int k = 0; k < 3000 && q.size() != 0; k++)
            @(negedge clock);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d items left required 0",
                     name, q.size());
            q.delete();
        end
    endtask

    task automatic run(input string name, input int n,
                       input logic [15:0] gp, input logic [15:0] gc,
                       input int dly);
        int eb, cb, bad;
        logic [15:0] r;
        eb = $urandom_range(0, 1000);
        cb = $urandom_range(2000, 3000);
        shl_delay = dly;
        load(n, eb, cb);
        for (int i = 0; i < n; i++) begin
            r = ref_exc(ev[i], cv[i], gp, gc);
            q.push_back('{0, eb + i, {{16{r[15]}}, r}, 0});
        end
        q.push_back('{1, 0, 32'h0, 2 + (7 + dly) * n});
        kick(n, gp, gc, eb, cb);
        wait_empty(name);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            r = ref_exc(ev[i], cv[i], gp, gc);
            if (mem[eb + i] !== {{16{r[15]}}, r}) bad++;
            if (mem[cb + i] !== cw[i]) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_mem: %0d bad words required 0", name, bad);
        end
    endtask

    initial begin
        int eb, cb;
        reset     = 1'b1;
        start     = 1'b0;
        exc       = '0;
        code      = '0;
        gain_pit  = '0;
        gain_code = '0;
        L_SUBFR   = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (2) @(negedge clock);
        tests++;
        if (done || memWriteEn || L_shlReady || addOutA != 0 ||
            memReadAddr != 0) begin
            fails++;
            $display("FAIL reset_out: done=%b we=%b rdy=%b required 0",
                     done, memWriteEn, L_shlReady);
        end
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (done || memWriteEn) begin
            fails++;
            $display("FAIL idle_out: done=%b we=%b required 0",
                     done, memWriteEn);
        end

        ev[0] = 16'h1000; cv[0] = 16'h2000;
        run("vec1", 1, 16'h2000, 16'h0800, 0);
        ev[0] = 16'hF000; cv[0] = 16'h0000;
        run("vec2", 1, 16'h2000, 16'h0000, 0);
        ev[0] = 16'h7FFF; cv[0] = 16'h7FFF;
        run("vec3", 1, 16'h7FFF, 16'h7FFF, 0);

        for (int i = 0; i < 40; i++) begin
            ev[i] = 16'(i * 800 - 16000);
            cv[i] = 16'(12000 - i * 613);
        end
        run("ramp40", 40, 16'h3000, 16'h1234, 0);

        for (int i = 0; i < 40; i++) begin
            ev[i] = 16'($urandom);
            cv[i] = 16'($urandom);
        end
        run("delay3", 40, 16'($urandom), 16'($urandom), 3);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                ev[i] = 16'($urandom);
                cv[i] = 16'($urandom);
            end
            run("rand", n, 16'($urandom), 16'($urandom),
                $urandom_range(0, 2));
        end

        run("zero", 0, 16'h1111, 16'h2222, 0);

        // Reset while sample 6 is in its write cycle.
        for (int i = 0; i < 40; i++) begin
            ev[i] = 16'($urandom);
            cv[i] = 16'($urandom);
        end
        eb = 100;
        cb = 2500;
        shl_delay = 0;
        load(40, eb, cb);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] r;
            r = ref_exc(ev[i], cv[i], 16'h2345, 16'h0777);
            q.push_back('{0, eb + i, {{16{r[15]}}, r}, 0});
        end
        kick(40, 16'h2345, 16'h0777, eb, cb);
        for (int k = 0; k < 200 && cyc - start_cyc < 46; k++)
            @(negedge clock);
        @(posedge clock);
        #1;
        tests++;
        if (memWriteEn !== 1'b1) begin
            fails++;
            $display("FAIL pre_rst_we: got %b required 1", memWriteEn);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (memWriteEn !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_we: we=%b done=%b required 0",
                     memWriteEn, done);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL rst_writes: %0d missing required 0", q.size());
            q.delete();
        end
        tests++;
        if (mem[eb + 6] !== ew[6] || mem[eb + 39] !== ew[39]) begin
            fails++;
            $display("FAIL rst_mem: %h required %h",
                     mem[eb + 6], ew[6]);
        end
        run("rst_zero", 0, 16'h4000, 16'h4000, 0);
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
